// File: rtl/alu_seq_exec.sv
// alu_seq_exec: sequential 8-bit ALU front-end with valid/ready request and response handshakes
module alu_seq_exec (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [7:0] x_i,
    input  logic [7:0] y_i,
    input  logic [2:0] op_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [7:0] r_o,
    output logic       fz_o,
    output logic       fc_o,
    output logic       err_o,
    output logic       c_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ADC = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;

    logic [1:0]  state_q, state_d;
    logic [7:0]  x_q, x_d, y_q, y_d, r_q, r_d;
    logic [2:0]  op_q, op_d, cnt_q, cnt_d;
    logic [15:0] prod_q, prod_d;
    logic        fz_q, fz_d, fc_q, fc_d, err_q, err_d, c_q, c_d;
    logic [8:0]  sum;
    logic [15:0] pp;

    // Next-state and datapath: single-cycle add/sub/adc, one multiplier bit per EXEC cycle for MUL
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        r_d     = r_q;
        fz_d    = fz_q;
        fc_d    = fc_q;
        err_d   = err_q;
        c_d     = c_q;
        sum     = (op_q == OP_SUB) ? {1'b0, x_q} - {1'b0, y_q}
                                   : {1'b0, x_q} + {1'b0, y_q} + {8'h00, (op_q == OP_ADC) & c_q};
        pp      = prod_q + (x_q[cnt_q] ? ({8'h00, y_q} << cnt_q) : 16'h0000);
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    x_d     = x_i;
                    y_d     = y_i;
                    op_d    = op_i;
                    cnt_d   = 3'd0;
                    prod_d  = 16'h0000;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (op_q[2]) begin
                    r_d     = 8'h00;
                    fz_d    = 1'b0;
                    fc_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (op_q == OP_MUL) begin
                    prod_d = pp;
                    cnt_d  = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        r_d     = pp[7:0];
                        fc_d    = |pp[15:8];
                        fz_d    = (pp[7:0] == 8'h00);
                        err_d   = 1'b0;
                        c_d     = |pp[15:8];
                        state_d = RESP;
                    end
                end else begin
                    r_d     = sum[7:0];
                    fc_d    = sum[8];
                    fz_d    = (sum[7:0] == 8'h00);
                    err_d   = 1'b0;
                    c_d     = sum[8];
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset discards any in-flight operation and clears the carry
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            x_q     <= 8'h00;
            y_q     <= 8'h00;
            op_q    <= 3'b000;
            cnt_q   <= 3'd0;
            prod_q  <= 16'h0000;
            r_q     <= 8'h00;
            fz_q    <= 1'b0;
            fc_q    <= 1'b0;
            err_q   <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            r_q     <= r_d;
            fz_q    <= fz_d;
            fc_q    <= fc_d;
            err_q   <= err_d;
            c_q     <= c_d;
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign r_o         = r_q;
    assign fz_o        = fz_q;
    assign fc_o        = fc_q;
    assign err_o       = err_q;
    assign c_o         = c_q;
endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: randomized and directed self-checking bench for alu_seq_exec
module tb_alu_seq_exec;
    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic [7:0] x_i = 8'h00;
    logic [7:0] y_i = 8'h00;
    logic [2:0] op_i = 3'b000;
    logic       rsp_valid_o;
    logic       rsp_ready_i = 1'b0;
    logic [7:0] r_o;
    logic       fz_o, fc_o, err_o, c_o;

    int checks = 0;
    int errors = 0;
    int c_model = 0;

    alu_seq_exec dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .x_i(x_i), .y_i(y_i), .op_i(op_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .r_o(r_o), .fz_o(fz_o), .fc_o(fc_o), .err_o(err_o), .c_o(c_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: arithmetic straight from the operation rules, carry kept in c_model
    task automatic model(input int a, input int b, input int op, output int r, output int fz,
                         output int fc, output int err, output int lat);
        int s;
        err = 0;
        lat = 1;
        s   = 0;
        case (op)
            0: s = a + b;
            1: s = a - b;
            2: s = a + b + c_model;
            3: begin s = a * b; lat = 8; end
            default: err = 1;
        endcase
        if (err == 1) begin
            r = 0; fz = 0; fc = 0;
        end else begin
            r  = (s + 256) % 256;
            fc = (op == 1) ? int'(a < b) : int'(s > 255);
            fz = int'(r == 0);
            c_model = fc;
        end
    endtask

    // Issue one request with rsp_ready_i high, scramble inputs while busy, capture the response
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                          output int r, output int fz, output int fc, output int err,
                          output int c, output int lat);
        req_valid_i = 1'b1; x_i = a; y_i = b; op_i = op; rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        lat = 0;
        do begin
            x_i = 8'($urandom); y_i = 8'($urandom); op_i = 3'($urandom);
            @(posedge clk_i); #1;
            lat++;
        end while (!rsp_valid_o && lat < 20);
        r = int'(r_o); fz = int'(fz_o); fc = int'(fc_o); err = int'(err_o); c = int'(c_o);
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        #2;
        checks++;
        if ({rsp_valid_o, r_o, fz_o, fc_o, err_o, c_o} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b r=%0d fz=%0b fc=%0b err=%0b c=%0b, want all 0",
                     rsp_valid_o, r_o, fz_o, fc_o, err_o, c_o);
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        c_model = 0;
        @(posedge clk_i); #1;
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %0b want 1", req_ready_o);
        end
    endtask

    task automatic test_arith;
        int tv [8][8] = '{
            '{0,   1,   1,   2, 0, 0, 0, 1},
            '{1,   7,   3,   4, 0, 0, 0, 1},
            '{1,   2,   2,   0, 1, 0, 0, 1},
            '{1,   3,   4, 255, 0, 1, 1, 1},
            '{0, 255,   1,   0, 1, 1, 1, 1},
            '{2,   0,   0,   1, 0, 0, 0, 1},
            '{3,  16,  16,   0, 1, 1, 1, 8},
            '{3,  12,  10, 120, 0, 0, 0, 8}
        };
        int r, fz, fc, err, c, lat;
        for (int i = 0; i < 8; i++) begin
            run_op(8'(tv[i][1]), 8'(tv[i][2]), 3'(tv[i][0]), r, fz, fc, err, c, lat);
            checks++;
            if (r !== tv[i][3] || fz !== tv[i][4] || fc !== tv[i][5] || c !== tv[i][6] ||
                err !== 0 || lat !== tv[i][7]) begin
                errors++;
                $display("FAIL arith[%0d]: got r=%0d fz=%0d fc=%0d c=%0d err=%0d lat=%0d, want r=%0d fz=%0d fc=%0d c=%0d err=0 lat=%0d",
                         i, r, fz, fc, c, err, lat, tv[i][3], tv[i][4], tv[i][5], tv[i][6], tv[i][7]);
            end
        end
        c_model = 0;
    endtask

    task automatic test_illegal;
        int r, fz, fc, err, c, lat;
        run_op(8'd255, 8'd1, 3'b000, r, fz, fc, err, c, lat);
        run_op(8'd9, 8'd4, 3'b101, r, fz, fc, err, c, lat);
        checks++;
        if (r !== 0 || fz !== 0 || fc !== 0 || err !== 1 || c !== 1 || lat !== 1) begin
            errors++;
            $display("FAIL illegal: got r=%0d fz=%0d fc=%0d err=%0d c=%0d lat=%0d, want r=0 fz=0 fc=0 err=1 c=1 lat=1",
                     r, fz, fc, err, c, lat);
        end
        c_model = 1;
    endtask

    task automatic test_back_to_back_hold;
        int n;
        logic seen;
        req_valid_i = 1'b1; x_i = 8'h30; y_i = 8'h05; op_i = 3'b000; rsp_ready_i = 1'b0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        n = 0;
        while (!rsp_valid_o && n < 20) begin @(posedge clk_i); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            req_valid_i = ~req_valid_i; x_i = 8'($urandom); y_i = 8'($urandom); op_i = 3'($urandom_range(0, 3));
            @(posedge clk_i); #1;
            checks++;
            if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0 || r_o !== 8'h35 || fz_o !== 1'b0 ||
                fc_o !== 1'b0 || err_o !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: got valid=%0b ready=%0b r=%0d fz=%0b fc=%0b err=%0b, want valid=1 ready=0 r=53 fz=0 fc=0 err=0",
                         i, rsp_valid_o, req_ready_o, r_o, fz_o, fc_o, err_o);
            end
        end
        req_valid_i = 1'b0; rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got valid=%0b ready=%0b, want valid=0 ready=1", rsp_valid_o, req_ready_o);
        end
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            seen |= rsp_valid_o | ~req_ready_o;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL hold_no_second_accept: got activity=%0b want 0", seen);
        end
        c_model = 0;
    endtask

    task automatic test_random(input int count);
        int a, b, op, r, fz, fc, err, c, lat;
        int er, efz, efc, eerr, elat;
        for (int i = 0; i < count; i++) begin
            a  = int'($urandom_range(0, 255));
            b  = int'($urandom_range(0, 255));
            op = int'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) op = 3;
            model(a, b, op, er, efz, efc, eerr, elat);
            run_op(8'(a), 8'(b), 3'(op), r, fz, fc, err, c, lat);
            checks++;
            if (r !== er || fz !== efz || fc !== efc || err !== eerr || c !== c_model || lat !== elat) begin
                errors++;
                $display("FAIL random[%0d] op=%0d x=%0d y=%0d: got r=%0d fz=%0d fc=%0d err=%0d c=%0d lat=%0d, want r=%0d fz=%0d fc=%0d err=%0d c=%0d lat=%0d",
                         i, op, a, b, r, fz, fc, err, c, lat, er, efz, efc, eerr, c_model, elat);
            end
        end
    endtask

    task automatic test_reset_mid_mul;
        int r, fz, fc, err, c, lat;
        logic seen;
        run_op(8'd200, 8'd100, 3'b000, r, fz, fc, err, c, lat);
        req_valid_i = 1'b1; x_i = 8'd13; y_i = 8'd11; op_i = 3'b011; rsp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        repeat (4) begin @(posedge clk_i); #1; end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({rsp_valid_o, r_o, fz_o, fc_o, err_o, c_o} !== 13'h0) begin
            errors++;
            $display("FAIL reset_mid_mul: got valid=%0b r=%0d fz=%0b fc=%0b err=%0b c=%0b, want all 0",
                     rsp_valid_o, r_o, fz_o, fc_o, err_o, c_o);
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        c_model = 0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_i); #1;
            seen |= rsp_valid_o | ~req_ready_o | c_o;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_mul_no_rsp: got activity=%0b want 0", seen);
        end
    endtask

    initial begin
        test_reset;
        test_arith;
        test_illegal;
        test_back_to_back_hold;
        test_random(40);
        test_reset_mid_mul;
        test_random(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
